im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Boot-time writer for instruction memory.
- Accepts a big-endian byte stream over a valid/ready handshake and assembles it into 32-bit words.
- Writes each word to consecutive word-aligned instruction memory addresses.
- Holds the CPU in reset until the programmed word count has been written, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- CNT_W, 16, width of the word counter and the word_count port.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- start  input  1  one-cycle pulse that begins a load; word_count is sampled on the same cycle.
- word_count  input  CNT_W  number of 32-bit words to load.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction memory write strobe.
- im_addr  output  32  instruction memory byte address (word aligned).
- im_wdata  output  32  instruction memory write data.
- cpu_hold  output  1  1 = CPU held in reset.
- busy  output  1  load in progress.
- done  output  1  load complete.
- checksum  output  32  XOR of all words written in the current load.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; cpu_hold=1.
  - byte_ready, im_we, busy, done = 0.
  - im_addr=BASE_ADDR; im_wdata=0; checksum=0.
  - Byte index and word index = 0.
  - Reset overrides everything, including mid-load. A partially assembled word is discarded and never written.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - cpu_hold=1.
  - On start: latch word_count into cnt; clear checksum, byte index and word index.
  - If cnt==0, go to DONE; otherwise go to RECV.
- RECV:
  - byte_ready=1, busy=1.
  - A byte is accepted only when byte_valid & byte_ready at a rising edge.
  - Assembly is big-endian: the first byte goes to bits [31:24], the fourth to [7:0]. Implement as a left shift of the assembly register by 8 with the new byte in [7:0].
  - When the 4th byte is accepted, transition to WRITE in the next cycle.
  - byte_valid without acceptance has no effect.
- WRITE:
  - Exactly one cycle: im_we=1, im_wdata=assembled word, im_addr=BASE_ADDR + 4*word_idx (modulo 2^32), byte_ready=0.
  - checksum ^= word.
  - word_idx increments. If the new word_idx==cnt, go to DONE; otherwise return to RECV with byte index 0.
- DONE:
  - cpu_hold=0, done=1, busy=0, byte_ready=0.
  - Holds indefinitely.
  - A start pulse in DONE re-enters the IDLE start path in the same cycle: cpu_hold asserts on the next cycle and a fresh load begins (reload).
- start in RECV or WRITE is ignored.
- Latency: each word takes 4 accepted byte cycles plus 1 WRITE cycle, so 5 cycles per word minimum under back-to-back valid.
  - A full load of N>0 words reaches DONE 5N+1 cycles after start, counting the start cycle as cycle 0.
- im_addr holds its last value outside WRITE. im_we is never asserted outside WRITE.
- Counter rules:
  - cnt is CNT_W bits unsigned; maximum load is 2^CNT_W - 1 words.
  - word_idx never wraps within a load, because comparison with cnt terminates first.
- Simultaneous start and reset: reset wins.
- byte_in is only sampled on accepted beats.

Decomposition:
- Shared package cpu_pkg:
  - State enum (IDLE/RECV/WRITE/DONE, 2-bit encoding).
  - Constants WORD_BYTES=4 and IM_BASE_DEFAULT.
- One sub-module, byte_packer:
  - Owns the 2-bit byte index and 32-bit shift register.
  - Inputs: clk, rst, clear, accept, byte_in.
  - Outputs: word, word_full (asserted the cycle after the 4th accept).
- The FSM, address/word counters and checksum live in im_loader.

Test Plan:
- Reset then idle 10 cycles → cpu_hold=1, done=0, im_we never asserted, byte_ready=0.
- start with word_count=2; bytes 8C,01,00,04,AC,22,00,08 with byte_valid held high:
  - im_we pulses twice: addr 0x0 data 0x8C010004, then addr 0x4 data 0xAC220008.
  - checksum=0x20230 00C (0x8C010004 ^ 0xAC220008 = 0x2023000C).
  - done=1 and cpu_hold=0 at cycle 11 after start.
- Same load with byte_valid toggling 1/0 every cycle → identical writes and data; done delayed accordingly; no extra or dropped bytes.
- start with word_count=0 → DONE one cycle later, no im_we, checksum=0, cpu_hold=0.
- rst=0 asserted after 2 bytes of word 1 in a 3-word load:
  - Next cycle: IDLE, cpu_hold=1, no write of the partial word.
  - Subsequent start reloads from BASE_ADDR.
- start pulsed during RECV is ignored (cnt unchanged). start pulsed in DONE → cpu_hold returns to 1 and the second load overwrites from BASE_ADDR.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES      = 4;
  localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Big-endian byte-to-word assembler: the first accepted byte ends up in bits [31:24].
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full,
  output logic        last_byte
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] sr_q, sr_d;
  logic        full_q, full_d;

  always_comb begin
    idx_d  = idx_q;
    sr_d   = sr_q;
    full_d = 1'b0;
    if (clear) begin
      idx_d = '0;
      sr_d  = '0;
    end else if (accept) begin
      sr_d   = {sr_q[23:0], byte_in};
      idx_d  = idx_q + 2'd1;
      full_d = (idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q  <= '0;
      sr_q   <= '0;
      full_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      sr_q   <= sr_d;
      full_q <= full_d;
    end
  end

  assign word      = sr_q;
  assign word_full = full_q;
  // Lets the FSM leave RECV on the edge that takes the 4th byte, so WRITE follows directly.
  assign last_byte = (idx_q == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Boot-time loader: streams bytes into instruction memory, holds the CPU in reset until done.
module im_loader
  import cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IM_BASE_DEFAULT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      im_addr_q, im_addr_d;
  logic [31:0]      checksum_q, checksum_d;
  logic             byte_ready_q, byte_ready_d;
  logic             im_we_q, im_we_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept, clear, word_full, last_byte;
  logic [31:0]      word;

  assign accept = byte_ready_q & byte_valid;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .accept    (accept),
    .byte_in   (byte_in),
    .word      (word),
    .word_full (word_full),
    .last_byte (last_byte)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_idx_d   = word_idx_q;
    im_addr_d    = im_addr_q;
    checksum_d   = checksum_q;
    byte_ready_d = byte_ready_q;
    im_we_d      = 1'b0;
    cpu_hold_d   = cpu_hold_q;
    busy_d       = busy_q;
    done_d       = done_q;
    clear        = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d      = word_count;
          word_idx_d = '0;
          checksum_d = '0;
          clear      = 1'b1;
          if (word_count == '0) begin
            state_d      = S_DONE;
            cpu_hold_d   = 1'b0;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            byte_ready_d = 1'b0;
          end else begin
            state_d      = S_RECV;
            cpu_hold_d   = 1'b1;
            done_d       = 1'b0;
            busy_d       = 1'b1;
            byte_ready_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (accept && last_byte) begin
          state_d      = S_WRITE;
          byte_ready_d = 1'b0;
          im_we_d      = 1'b1;
          im_addr_d    = BASE_ADDR + (32'(word_idx_q) * 32'(WORD_BYTES));
        end
      end
      S_WRITE: begin
        if (word_full) begin
          checksum_d = checksum_q ^ word;
          word_idx_d = word_idx_q + CNT_W'(1);
          if (word_idx_d == cnt_q) begin
            state_d    = S_DONE;
            cpu_hold_d = 1'b0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
          end else begin
            state_d      = S_RECV;
            byte_ready_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      word_idx_q   <= '0;
      im_addr_q    <= BASE_ADDR;
      checksum_q   <= '0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_idx_q   <= word_idx_d;
      im_addr_q    <= im_addr_d;
      checksum_q   <= checksum_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = word;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: normal, throttled, empty, aborted and restarted loads.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  im_loader #(.BASE_ADDR(32'h0000_0000), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  logic [7:0] stream [12] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h22, 8'h00, 8'h08,
                              8'h11, 8'h22, 8'h33, 8'h44};

  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int n_chk = 0;
  int n_bad = 0;

  always @(posedge clk) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Pulses start, then feeds bytes; returns the cycle (start edge = end of cycle 0) where done is seen.
  task automatic run_load(input int n, input bit toggle, input int stop_at, input int spur_cyc,
                          output int done_cyc, output logic hold1);
    int  idx = 0;
    int  cyc;
    logic acc;
    done_cyc = -1;
    @(negedge clk);
    start      = 1'b1;
    word_count = n[15:0];
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    hold1 = cpu_hold;
    while (cyc < 300) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (idx == stop_at) break;
      start      = (cyc == spur_cyc);
      word_count = 16'd5;
      byte_valid = (!toggle || (cyc % 2 == 1)) && (idx < 4 * n);
      byte_in    = (byte_valid && idx < 12) ? stream[idx] : 8'h5A;
      #1;
      acc = byte_valid && byte_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b0;
      cyc++;
    end
    start      = 1'b0;
    byte_valid = 1'b0;
  endtask

  initial begin
    int   dc;
    logic h1;
    rst        = 1'b0;
    start      = 1'b0;
    word_count = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold",   32'(cpu_hold),   32'd1);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_ready",  32'(byte_ready), 32'd0);
    chk("rst_we",     32'(im_we),      32'd0);
    chk("rst_addr",   im_addr,         32'h0);
    chk("rst_wdata",  im_wdata,        32'h0);
    chk("rst_csum",   checksum,        32'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_hold",  32'(cpu_hold),   32'd1);
    chk("idle_ready", 32'(byte_ready), 32'd0);
    chk("idle_done",  32'(done),       32'd0);
    chk("idle_nowr",  32'(wr_addr.size()), 32'd0);

    // Two words, back-to-back bytes
    clear_log();
    run_load(2, 1'b0, -1, -1, dc, h1);
    chk("b2b_hold1",  32'(h1), 32'd1);
    chk("b2b_cycle",  32'(dc), 32'd11);
    chk("b2b_nwr",    32'(wr_addr.size()), 32'd2);
    chk("b2b_addr0",  wr_addr[0], 32'h0);
    chk("b2b_data0",  wr_data[0], 32'h8C010004);
    chk("b2b_addr1",  wr_addr[1], 32'h4);
    chk("b2b_data1",  wr_data[1], 32'hAC220008);
    chk("b2b_csum",   checksum, 32'h2023000C);
    chk("b2b_hold",   32'(cpu_hold), 32'd0);
    chk("b2b_busy",   32'(busy), 32'd0);
    chk("b2b_addrh",  im_addr, 32'h4);

    // Same load with byte_valid toggling
    do_reset();
    clear_log();
    run_load(2, 1'b1, -1, -1, dc, h1);
    chk("tog_cycle",  32'(dc), 32'd17);
    chk("tog_nwr",    32'(wr_addr.size()), 32'd2);
    chk("tog_data0",  wr_data[0], 32'h8C010004);
    chk("tog_addr1",  wr_addr[1], 32'h4);
    chk("tog_data1",  wr_data[1], 32'hAC220008);
    chk("tog_csum",   checksum, 32'h2023000C);

    // Empty load
    do_reset();
    clear_log();
    run_load(0, 1'b0, -1, -1, dc, h1);
    chk("zero_cycle", 32'(dc), 32'd1);
    chk("zero_nwr",   32'(wr_addr.size()), 32'd0);
    chk("zero_csum",  checksum, 32'h0);
    chk("zero_hold",  32'(cpu_hold), 32'd0);

    // Reset in the middle of the second word of a 3-word load
    do_reset();
    clear_log();
    run_load(3, 1'b0, 6, -1, dc, h1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_hold",  32'(cpu_hold), 32'd1);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_ready", 32'(byte_ready), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_nwr",   32'(wr_addr.size()), 32'd1);
    clear_log();
    run_load(2, 1'b0, -1, -1, dc, h1);
    chk("relo_cycle",  32'(dc), 32'd11);
    chk("relo_addr0",  wr_addr[0], 32'h0);
    chk("relo_data0",  wr_data[0], 32'h8C010004);

    // Start pulse during RECV must be ignored
    do_reset();
    clear_log();
    run_load(2, 1'b0, -1, 3, dc, h1);
    chk("spur_cycle",  32'(dc), 32'd11);
    chk("spur_nwr",    32'(wr_addr.size()), 32'd2);
    chk("spur_data1",  wr_data[1], 32'hAC220008);
    chk("spur_csum",   checksum, 32'h2023000C);

    // Restart straight from DONE
    clear_log();
    run_load(1, 1'b0, -1, -1, dc, h1);
    chk("again_hold1", 32'(h1), 32'd1);
    chk("again_cycle", 32'(dc), 32'd6);
    chk("again_nwr",   32'(wr_addr.size()), 32'd1);
    chk("again_addr0", wr_addr[0], 32'h0);
    chk("again_data0", wr_data[0], 32'h8C010004);
    chk("again_csum",  checksum, 32'h8C010004);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
